// File: rtl/barret_reduce_pipe_if.sv
// barret_reduce_pipe_if: operand/result handshake bundle for barret_reduce_pipe.
// The slave modport is the reducer side; the master modport is the producer/consumer side.
// K and TAG_W must match the parameters of the reducer instance this bundle is bound to.
interface barret_reduce_pipe_if #(
    parameter int K     = 11,
    parameter int TAG_W = 8
);
    logic [2*K-1:0]   din_a;
    logic [TAG_W-1:0] din_tag;
    logic             din_valid;
    logic             din_ready;
    logic [K-1:0]     dout_r;
    logic [TAG_W-1:0] dout_tag;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;

    modport slave (
        input  din_a, din_tag, din_valid, dout_ready,
        output din_ready, dout_r, dout_tag, dout_valid, busy
    );

    modport master (
        output din_a, din_tag, din_valid, dout_ready,
        input  din_ready, dout_r, dout_tag, dout_valid, busy
    );
endinterface

// File: rtl/barret_reduce_pipe.sv
// barret_reduce_pipe: three-stage pipelined Barrett reducer, dout_r = din_a mod Q.
// S1 holds the operand, S2 holds the quotient estimate, S3 holds the corrected result.
// All stages advance together whenever the output slot is empty or being taken.
// Optional transfer statistics are compiled in when BARRET_STATS_EN is defined.
module barret_reduce_pipe #(
    parameter int Q     = 1607,
    parameter int K     = 11,
    parameter int TAG_W = 8
) (
    input  logic                clk,
    input  logic                rst,
`ifdef BARRET_STATS_EN
    input  logic                clr_stats,
    output logic [31:0]         stat_count,
    output logic [31:0]         stat_dbl,
`endif
    barret_reduce_pipe_if.slave bus
);
    // Barrett constant floor(2^(2K)/Q); fits in K+1 bits because Q > 2^(K-1).
    localparam logic [K:0]   MU  = (K+1)'((64'd1 << (2*K)) / 64'(Q));
    localparam logic [K+1:0] Q_R = (K+2)'(Q);
    localparam logic [2*K:0] Q_T = (2*K+1)'(Q);

    logic             adv;

    logic             s1_v_q;
    logic [2*K-1:0]   s1_x_q;
    logic [TAG_W-1:0] s1_tag_q;

    // Only the low K+2 bits of x are needed past S1: the remainder x - qh*Q is
    // known to lie in [0, 3Q), so it is exact modulo 2^(K+2).
    logic             s2_v_q;
    logic [K+1:0]     s2_x_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [K:0]       s2_qh_q;
    logic [K:0]       s2_qh_d;

    logic             s3_v_q;
    logic [K-1:0]     s3_r_q;
    logic [K-1:0]     s3_r_d;
    logic [TAG_W-1:0] s3_tag_q;

    logic [K:0]       x_hi;
    logic [K+1:0]     r0;
    logic [K+1:0]     r1;
    logic             sub1;
    logic             sub2;

    // The pipe moves only when the output register is free or is being read this cycle.
    assign adv = !s3_v_q | bus.dout_ready;

    // Quotient estimate from S1, remainder and up to two corrective subtractions from S2.
    always_comb begin
        // NOTE: every variable in this block is assigned on every path, so no latch is inferred.
        x_hi    = s1_x_q[2*K-1:K-1];
        s2_qh_d = (K+1)'(((2*K+2)'(x_hi) * (2*K+2)'(MU)) >> (K+1));
        r0      = s2_x_q - (K+2)'((2*K+1)'(s2_qh_q) * Q_T);
        sub1    = (r0 >= Q_R);
        r1      = sub1 ? (r0 - Q_R) : r0;
        sub2    = (r1 >= Q_R);
        s3_r_d  = K'(sub2 ? (r1 - Q_R) : r1);
    end

    // Pipeline registers: load together on adv, otherwise every stage holds.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so each stage samples the
        // previous stage's pre-edge value, which is what makes this a pipeline.
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_x_q   <= '0;
            s1_tag_q <= '0;
            s2_v_q   <= 1'b0;
            s2_x_q   <= '0;
            s2_tag_q <= '0;
            s2_qh_q  <= '0;
            s3_v_q   <= 1'b0;
            s3_r_q   <= '0;
            s3_tag_q <= '0;
        end else if (adv) begin
            s1_v_q   <= bus.din_valid;
            s1_x_q   <= bus.din_a;
            s1_tag_q <= bus.din_tag;
            s2_v_q   <= s1_v_q;
            s2_x_q   <= s1_x_q[K+1:0];
            s2_tag_q <= s1_tag_q;
            s2_qh_q  <= s2_qh_d;
            s3_v_q   <= s2_v_q;
            s3_r_q   <= s3_r_d;
            s3_tag_q <= s2_tag_q;
        end
    end

    assign bus.din_ready  = adv;
    assign bus.dout_valid = s3_v_q;
    assign bus.dout_r     = s3_r_q;
    assign bus.dout_tag   = s3_tag_q;
    assign bus.busy       = s1_v_q | s2_v_q | s3_v_q;

`ifdef BARRET_STATS_EN
    logic        s3_dbl_q;
    logic        out_xfer;
    logic [31:0] stat_count_q;
    logic [31:0] stat_dbl_q;

    assign out_xfer = s3_v_q & bus.dout_ready;

    // Remember whether the result now in S3 needed both corrective subtractions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_dbl_q <= 1'b0;
        end else if (adv) begin
            s3_dbl_q <= sub2;
        end
    end

    // Transfer counters; a clear takes priority over a coincident transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_count_q <= '0;
            stat_dbl_q   <= '0;
        end else if (clr_stats) begin
            stat_count_q <= '0;
            stat_dbl_q   <= '0;
        end else if (out_xfer) begin
            stat_count_q <= stat_count_q + 32'd1;
            if (s3_dbl_q) begin
                stat_dbl_q <= stat_dbl_q + 32'd1;
            end
        end
    end

    assign stat_count = stat_count_q;
    assign stat_dbl   = stat_dbl_q;
`endif
endmodule

// File: tb/tb_barret_reduce_pipe.sv
// tb_barret_reduce_pipe: directed and randomized checks of barret_reduce_pipe.
// Expected results come from plain modular arithmetic (din_a % Q) held in an
// in-order queue; a second instance covers the Q = 3329, K = 12 configuration.
module tb_barret_reduce_pipe;
    localparam int Q     = 1607;
    localparam int K     = 11;
    localparam int TAG_W = 8;
    localparam int QB    = 3329;
    localparam int KB    = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    barret_reduce_pipe_if #(.K(K),  .TAG_W(TAG_W)) a_if ();
    barret_reduce_pipe_if #(.K(KB), .TAG_W(TAG_W)) b_if ();

`ifdef BARRET_STATS_EN
    logic        clr_a;
    logic        clr_b;
    logic [31:0] sc_a;
    logic [31:0] sd_a;
    logic [31:0] sc_b;
    logic [31:0] sd_b;
`endif

    barret_reduce_pipe #(.Q(Q), .K(K), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef BARRET_STATS_EN
        .clr_stats  (clr_a),
        .stat_count (sc_a),
        .stat_dbl   (sd_a),
`endif
        .bus        (a_if.slave)
    );

    barret_reduce_pipe #(.Q(QB), .K(KB), .TAG_W(TAG_W)) dut_b (
        .clk        (clk),
        .rst        (rst),
`ifdef BARRET_STATS_EN
        .clr_stats  (clr_b),
        .stat_count (sc_b),
        .stat_dbl   (sd_b),
`endif
        .bus        (b_if.slave)
    );

    typedef struct {
        logic [K-1:0]     r;
        logic [TAG_W-1:0] tag;
    } item_t;

    item_t exp_q[$];

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int n_acc     = 0;
    int n_out     = 0;
    int first_acc = -1;
    int first_out = -1;
    int last_out  = -1;

    logic [K-1:0]     nxt_exp;
    logic             hold_v = 1'b0;
    logic [K-1:0]     hold_r;
    logic [TAG_W-1:0] hold_tag;

    int unsigned corner_a [5] = '{2579236, 4194303, 1607, 3214, 1606};
    int unsigned corner_r [5] = '{1, 33, 0, 0, 1606};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_acc     = 0;
        n_out     = 0;
        first_acc = -1;
        first_out = -1;
        last_out  = -1;
    endtask

    task automatic drive(input logic v, input logic [2*K-1:0] a, input logic [TAG_W-1:0] tg,
                         input logic [K-1:0] e);
        a_if.din_valid = v;
        a_if.din_a     = a;
        a_if.din_tag   = tg;
        nxt_exp        = e;
    endtask

    // One clock of the default instance: sample handshakes at the falling edge,
    // update the scoreboard, then return just after the next rising edge.
    task automatic cycle();
        item_t it;
        @(negedge clk);
        if (hold_v) begin
            check("hold_valid", a_if.dout_valid, 1);
            check("hold_r",     a_if.dout_r,     hold_r);
            check("hold_tag",   a_if.dout_tag,   hold_tag);
        end
        hold_v   = a_if.dout_valid && !a_if.dout_ready;
        hold_r   = a_if.dout_r;
        hold_tag = a_if.dout_tag;
        if (a_if.din_valid && a_if.din_ready) begin
            it.r   = nxt_exp;
            it.tag = a_if.din_tag;
            exp_q.push_back(it);
            if (first_acc < 0) first_acc = cyc;
            n_acc++;
        end
        if (a_if.dout_valid && a_if.dout_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", exp_q.size(), 1);
            end else begin
                it = exp_q.pop_front();
                check("out_r",   a_if.dout_r,   it.r);
                check("out_tag", a_if.dout_tag, it.tag);
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            n_out++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int unsigned a;
        int          guard;
        int          got;

        rst             = 1'b1;
        a_if.din_valid  = 1'b0;
        a_if.din_a      = '0;
        a_if.din_tag    = '0;
        a_if.dout_ready = 1'b0;
        b_if.din_valid  = 1'b0;
        b_if.din_a      = '0;
        b_if.din_tag    = '0;
        b_if.dout_ready = 1'b0;
        nxt_exp         = '0;
`ifdef BARRET_STATS_EN
        clr_a = 1'b0;
        clr_b = 1'b0;
`endif

        // Reset state.
        @(posedge clk);
        #2;
        check("rst_dout_valid", a_if.dout_valid, 0);
        check("rst_busy",       a_if.busy,       0);
        check("rst_dout_r",     a_if.dout_r,     0);
        check("rst_dout_tag",   a_if.dout_tag,   0);
`ifdef BARRET_STATS_EN
        check("rst_stat_count", sc_a, 0);
        check("rst_stat_dbl",   sd_a, 0);
`endif
        #1 rst = 1'b0;
        #1;
        check("rst_din_ready", a_if.din_ready, 1);
        @(posedge clk);
        #1;

        // Exhaustive low range streamed back-to-back: result equals the operand.
        clear_counts();
        a_if.dout_ready = 1'b1;
        for (int i = 0; i < Q; i++) begin
            drive(1'b1, (2*K)'(i), TAG_W'(i), K'(i));
            cycle();
        end
        drive(1'b0, '0, '0, '0);
        drain("low_drain", 20);
        check("low_accepts",  n_acc, Q);
        check("low_outputs",  n_out, Q);
        check("low_latency",  first_out - first_acc, 3);
        check("low_rate",     last_out - first_out, Q - 1);

        // Corner operands with fixed expected residues.
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (2*K)'(corner_a[i]), TAG_W'(8'h40 + i), K'(corner_r[i]));
            cycle();
        end
        drive(1'b0, '0, '0, '0);
        drain("corner_drain", 20);
        check("corner_outputs", n_out, 5);

        // Backpressure: three items in, output held for five cycles, then released.
        clear_counts();
        a_if.dout_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            a = $urandom & 32'h003F_FFFF;
            drive(1'b1, (2*K)'(a), TAG_W'(i), K'(a % Q));
            cycle();
        end
        drive(1'b0, '0, '0, '0);
        check("bp_valid", a_if.dout_valid, 1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_din_ready", a_if.din_ready, 0);
            check("bp_tag",       a_if.dout_tag,  1);
        end
        check("bp_no_out", n_out, 0);
        a_if.dout_ready = 1'b1;
        drain("bp_drain", 20);
        check("bp_outputs", n_out, 3);

        // Random stream with random input validity and output readiness.
        clear_counts();
        guard = 0;
        while (n_acc < 10000 && guard < 40000) begin
            a = $urandom & 32'h003F_FFFF;
            drive($urandom_range(0, 3) != 0, (2*K)'(a), TAG_W'(n_acc), K'(a % Q));
            a_if.dout_ready = ($urandom_range(0, 3) != 0);
            cycle();
            guard++;
        end
        check("rnd_accepts", n_acc, 10000);
        drive(1'b0, '0, '0, '0);
        a_if.dout_ready = 1'b1;
        drain("rnd_drain", 50);
        check("rnd_outputs", n_out, n_acc);

        // Reset with three items in flight.
        clear_counts();
        a_if.dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = $urandom & 32'h003F_FFFF;
            drive(1'b1, (2*K)'(a), TAG_W'(8'h90 + i), K'(a % Q));
            cycle();
        end
        drive(1'b0, '0, '0, '0);
        check("mid_busy_before", a_if.busy, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", a_if.dout_valid, 0);
        check("mid_rst_busy",  a_if.busy,       0);
        exp_q.delete();
        hold_v = 1'b0;
        #1 rst = 1'b0;
        clear_counts();
        a_if.dout_ready = 1'b1;
        drive(1'b1, 22'd1234, 8'hA5, K'(1234 % Q));
        cycle();
        drive(1'b0, '0, '0, '0);
        drain("mid_drain", 20);
        check("mid_outputs", n_out, 1);
        check("mid_latency", first_out - first_acc, 3);

        // Alternate modulus instance.
        b_if.dout_ready = 1'b1;
        b_if.din_valid  = 1'b1;
        b_if.din_a      = 24'd11075584;
        b_if.din_tag    = 8'd7;
        @(posedge clk);
        #1;
        b_if.din_a      = 24'd3329;
        b_if.din_tag    = 8'd8;
        @(posedge clk);
        #1;
        b_if.din_valid  = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            @(negedge clk);
            if (b_if.dout_valid) begin
                if (got == 0) begin
                    check("b_r0",   b_if.dout_r,   1);
                    check("b_tag0", b_if.dout_tag, 7);
                end else begin
                    check("b_r1",   b_if.dout_r,   0);
                    check("b_tag1", b_if.dout_tag, 8);
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        check("b_outputs", got, 2);
`ifdef BARRET_STATS_EN
        check("b_stat_count", sc_b, 2);
        clr_b = 1'b1;
        @(posedge clk);
        #1;
        clr_b = 1'b0;
        check("b_stat_count_clr", sc_b, 0);
        check("b_stat_dbl_clr",   sd_b, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
